// File: rtl/dec_onehot_seq.sv
// dec_onehot_seq
// Registered one-hot select generator. A select index is held in a register
// and decoded to a one-hot bus. The index can be loaded directly or scanned
// up/down with modulo-N wrap-around. Out depends only on registered state,
// so it is glitch-free and has no combinational path from the inputs.
//
// Ports
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset
//   en     in   global advance enable (0 freezes index/valid, wrap drops)
//   clr    in   synchronous clear of index and valid, independent of en
//   mode   in   00 direct, 01 scan-up, 10 scan-down, 11 hold
//   load   in   capture sel into the index (any mode)
//   sel    in   index to load
//   out    out  one-hot select, all zero while valid=0
//   index  out  registered index
//   valid  out  index established since last reset/clr
//   wrap   out  one-cycle pulse following a scan wrap
module dec_onehot_seq #(
    parameter int SEL_W = 4,
    localparam int N = 2 ** SEL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     out,
    output logic [SEL_W-1:0] index,
    output logic             valid,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    localparam logic [N-1:0]     ONE_HOT0 = N'(1);
    localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] IDX_MAX  = {SEL_W{1'b1}};

    logic [SEL_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        if (clr) begin
            idx_d   = '0;
            valid_d = 1'b0;
        end else if (!en) begin
            // frozen: keep index/valid, wrap already defaulted low
        end else if (load) begin
            idx_d   = sel;
            valid_d = 1'b1;
        end else begin
            case (mode_t'(mode))
                MODE_UP: begin
                    idx_d   = idx_q + IDX_ONE;
                    valid_d = 1'b1;
                    // the first step out of the invalid state never wraps
                    wrap_d  = valid_q && (idx_q == IDX_MAX);
                end
                MODE_DOWN: begin
                    idx_d   = idx_q - IDX_ONE;
                    valid_d = 1'b1;
                    wrap_d  = valid_q && (idx_q == '0);
                end
                default: begin
                    // direct without load, and hold: keep state
                end
            endcase
        end
    end

    assign out   = valid_q ? (ONE_HOT0 << idx_q) : '0;
    assign index = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_dec_onehot_seq.sv
module tb_dec_onehot_seq;

    logic        clock = 1'b0;
    logic        reset, en, clr, load;
    logic [1:0]  mode;
    logic [3:0]  sel;
    logic [15:0] out;
    logic [3:0]  index;
    logic        valid, wrap;

    logic        reset2;
    logic [3:0]  out2;
    logic [1:0]  index2;
    logic        valid2, wrap2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dec_onehot_seq #(.SEL_W(4)) dut (
        .clock(clock), .reset(reset), .en(en), .clr(clr), .mode(mode),
        .load(load), .sel(sel), .out(out), .index(index), .valid(valid),
        .wrap(wrap)
    );

    dec_onehot_seq #(.SEL_W(2)) dut2 (
        .clock(clock), .reset(reset2), .en(1'b1), .clr(1'b0), .mode(2'b01),
        .load(1'b0), .sel(2'b00), .out(out2), .index(index2), .valid(valid2),
        .wrap(wrap2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] e_out,
                             input logic [3:0] e_idx, input logic e_valid,
                             input logic e_wrap);
        chk({tag, ".out"},   32'(out),   32'(e_out));
        chk({tag, ".index"}, 32'(index), 32'(e_idx));
        chk({tag, ".valid"}, 32'(valid), 32'(e_valid));
        chk({tag, ".wrap"},  32'(wrap),  32'(e_wrap));
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        en = 1'b1; clr = 1'b0; load = 1'b0; mode = 2'b00; sel = 4'd0;

        // reset held for two cycles
        tick(); tick();
        chk_state("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // load 9 in direct mode, then hold with load low
        load = 1'b1; sel = 4'd9;
        tick();
        load = 1'b0;
        chk_state("load9", 16'h0200, 4'd9, 1'b1, 1'b0);
        tick();
        chk_state("hold9", 16'h0200, 4'd9, 1'b1, 1'b0);

        // direct sweep 0..15, expected out hand-derived as 1<<s
        for (int s = 0; s < 16; s++) begin
            load = 1'b1; sel = 4'(s);
            tick();
            chk("sweep.out", 32'(out), 32'(1) << s);
            chk("sweep.onehot", 32'($countones(out)), 32'd1);
        end
        load = 1'b0;

        // scan-up across the top
        load = 1'b1; sel = 4'd14;
        tick();
        load = 1'b0; mode = 2'b01;
        chk_state("up.load14", 16'h4000, 4'd14, 1'b1, 1'b0);
        tick();
        chk_state("up.15", 16'h8000, 4'd15, 1'b1, 1'b0);
        tick();
        chk_state("up.0",  16'h0001, 4'd0,  1'b1, 1'b1);
        tick();
        chk_state("up.1",  16'h0002, 4'd1,  1'b1, 1'b0);

        // scan-down with en toggling
        mode = 2'b00; load = 1'b1; sel = 4'd1;
        tick();
        load = 1'b0; mode = 2'b10;
        tick();
        chk_state("dn.0",   16'h0001, 4'd0,  1'b1, 1'b0);
        en = 1'b0;
        tick();
        chk_state("dn.en0", 16'h0001, 4'd0,  1'b1, 1'b0);
        en = 1'b1;
        tick();
        chk_state("dn.15",  16'h8000, 4'd15, 1'b1, 1'b1);
        tick();
        chk_state("dn.14",  16'h4000, 4'd14, 1'b1, 1'b0);

        // load beats scan
        mode = 2'b00; load = 1'b1; sel = 4'd5;
        tick();
        mode = 2'b01; sel = 4'd3;
        tick();
        chk_state("pri.load", 16'h0008, 4'd3, 1'b1, 1'b0);
        // clr beats load
        clr = 1'b1; sel = 4'd12;
        tick();
        clr = 1'b0; load = 1'b0;
        chk_state("pri.clr", 16'h0000, 4'd0, 1'b0, 1'b0);
        // scan resumes from 0, first step from invalid gives 1 with no wrap
        tick();
        chk_state("pri.resume", 16'h0002, 4'd1, 1'b1, 1'b0);

        // clr works with en low
        en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_state("clr.en0", 16'h0000, 4'd0, 1'b0, 1'b0);
        // first scan-down from invalid goes to N-1 with no wrap
        en = 1'b1; mode = 2'b10;
        tick();
        chk_state("dn.first", 16'h8000, 4'd15, 1'b1, 1'b0);

        // load applies in hold mode, hold then keeps it
        mode = 2'b11; load = 1'b1; sel = 4'd7;
        tick();
        load = 1'b0;
        chk_state("hold.load", 16'h0080, 4'd7, 1'b1, 1'b0);
        tick();
        chk_state("hold.keep", 16'h0080, 4'd7, 1'b1, 1'b0);

        // SEL_W=2 instance: continuous scan-up from reset
        chk("w2.reset.out", 32'(out2), 32'h0);
        chk("w2.reset.valid", 32'(valid2), 32'h0);
        reset2 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("w2.out",  32'(out2),  32'(1) << (k % 4));
            chk("w2.wrap", 32'(wrap2), 32'((k % 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
